// File: rtl/uart_rx_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_scoreboard_pkg
//  Description : Shared types and constants for the UART receive scoreboard.
//                Holds the scoreboard state enum, the byte width and the
//                saturation limit of the frame-error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_scoreboard_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] FRAME_ERR_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } sb_state_t;

endpackage : uart_rx_scoreboard_pkg
`default_nettype wire

// File: rtl/uart_sb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sb_fifo
//  Description : Synchronous first-word-fall-through FIFO. A push into a full
//                FIFO is still accepted when a pop happens in the same cycle.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                flush          - empties the FIFO (same effect as rst)
//                push, wdata    - write request and data
//                pop            - read request; rdata shows the head entry
//                full, empty    - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sb_fifo #(
    parameter int DEPTH = 8,   // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    // The slot freed by a simultaneous pop makes room for the push.
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wptr] <= wdata;
    end

endmodule : uart_sb_fifo
`default_nettype wire

// File: rtl/uart_rx_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_scoreboard
//  Description : Buffers decoded UART bytes and compares them in order with an
//                expected message. Reports pass/fail, first mismatch position,
//                overflow, frame-error count and (optionally) idle timeout.
//  Ports       : clk, rst                  - clock, synchronous active-high reset
//                rx_byte/rx_valid/rx_frame_err - decoded byte stream
//                expected                  - message, byte 0 in bits [7:0]
//                arm                       - start/restart a check
//                stall                     - holds off compare/pop
//                busy/done/pass/fail       - verdict
//                overflow/timeout          - sticky failure causes
//                mismatch_idx/got_byte     - first mismatch details
//                rcv_count/frame_err_cnt   - progress counters
//  Options     : UART_RX_SCOREBOARD_TIMEOUT_EN - builds the idle timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_scoreboard
    import uart_rx_scoreboard_pkg::*;
#(
    parameter int MSG_LEN        = 3,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    input  logic                       rx_frame_err,
    input  logic [8*MSG_LEN-1:0]       expected,
    input  logic                       arm,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       overflow,
    output logic                       timeout,
    output logic [$clog2(MSG_LEN):0]   mismatch_idx,
    output logic [7:0]                 got_byte,
    output logic [$clog2(MSG_LEN):0]   rcv_count,
    output logic [7:0]                 frame_err_cnt
);

    localparam int CW = $clog2(MSG_LEN) + 1;

    sb_state_t         r_state;
    sb_state_t         w_state_next;
    logic [CW-1:0]     r_rcv_count;
    logic [CW-1:0]     r_mismatch_idx;
    logic [BYTE_W-1:0] r_got_byte;
    logic [BYTE_W-1:0] r_frame_err_cnt;
    logic              r_overflow;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [BYTE_W-1:0] w_fifo_rdata;
    logic [BYTE_W-1:0] w_exp_byte;
    logic [CW-1:0]     w_rcv_next;
    logic w_run, w_push_req, w_pop, w_overflow;
    logic w_match, w_mismatch, w_pass_hit;
    logic w_timeout_hit, w_timeout_fail;

    // arm overrides everything in its cycle, so bytes strobed with it are dropped.
    assign w_run          = (r_state == ST_RUN) & ~arm;
    assign w_push_req     = w_run & rx_valid & ~rx_frame_err;
    assign w_pop          = w_run & ~w_fifo_empty & ~stall;
    assign w_overflow     = w_push_req & w_fifo_full & ~w_pop;
    assign w_match        = w_pop & (w_fifo_rdata == w_exp_byte);
    assign w_mismatch     = w_pop & ~w_match;
    assign w_pass_hit     = w_match & (r_rcv_count == CW'(MSG_LEN - 1));
    // A compare verdict in the same cycle takes precedence over the timeout.
    assign w_timeout_fail = w_timeout_hit & ~w_pass_hit & ~w_mismatch;
    assign w_rcv_next     = w_match ? r_rcv_count + 1'b1 : r_rcv_count;

    always_comb begin
        w_exp_byte = '0;
        for (int k = 0; k < MSG_LEN; k++) begin
            if (r_rcv_count == CW'(k)) w_exp_byte = expected[BYTE_W*k +: BYTE_W];
        end
    end

    uart_sb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (arm),
        .push  (w_push_req),
        .wdata (rx_byte),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_pass_hit)                                  w_state_next = ST_PASS;
            else if (w_mismatch | w_overflow | w_timeout_fail) w_state_next = ST_FAIL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_rcv_count     <= '0;
            r_mismatch_idx  <= '0;
            r_got_byte      <= '0;
            r_frame_err_cnt <= '0;
            r_overflow      <= 1'b0;
        end else if (w_run) begin
            r_rcv_count <= w_rcv_next;
            if (w_mismatch) begin
                r_mismatch_idx <= r_rcv_count;
                r_got_byte     <= w_fifo_rdata;
            end
            if (w_timeout_fail) r_mismatch_idx <= w_rcv_next;
            if (w_overflow)     r_overflow     <= 1'b1;
            if (rx_valid && rx_frame_err && (r_frame_err_cnt != FRAME_ERR_MAX))
                r_frame_err_cnt <= r_frame_err_cnt + 1'b1;
        end
    end

`ifdef UART_RX_SCOREBOARD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] r_idle_cnt;
    logic          r_timeout;

    // Counts RUN cycles since arm or the last strobe of any kind.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_run) begin
            r_idle_cnt <= rx_valid ? '0 : r_idle_cnt + 1'b1;
            if (w_timeout_fail) r_timeout <= 1'b1;
        end
    end

    assign w_timeout_hit = w_run & ~rx_valid & (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout       = r_timeout;
`else
    // TIMEOUT_CYCLES only matters when the timeout is built.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
    assign w_timeout_hit        = 1'b0;
    assign timeout              = 1'b0;
`endif

    assign busy          = (r_state == ST_RUN);
    assign pass          = (r_state == ST_PASS);
    assign fail          = (r_state == ST_FAIL);
    assign done          = pass | fail;
    assign overflow      = r_overflow;
    assign mismatch_idx  = r_mismatch_idx;
    assign got_byte      = r_got_byte;
    assign rcv_count     = r_rcv_count;
    assign frame_err_cnt = r_frame_err_cnt;

endmodule : uart_rx_scoreboard
`default_nettype wire

// File: tb/tb_uart_rx_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_scoreboard
//  Description : Self-checking bench for uart_rx_scoreboard: directed vector
//                table, hand-written corner sequences and randomized messages
//                checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_scoreboard;

    localparam int MSG_LEN = 3;
    localparam int DEPTH   = 8;
    localparam int TO      = 100;
    localparam int CW      = $clog2(MSG_LEN) + 1;

    logic                 clk = 1'b0;
    logic                 rst, rx_valid, rx_frame_err, arm, stall;
    logic [7:0]           rx_byte;
    logic [8*MSG_LEN-1:0] expected;
    wire                  busy, done, pass, fail, overflow, timeout;
    wire  [CW-1:0]        mismatch_idx, rcv_count;
    wire  [7:0]           got_byte, frame_err_cnt;

    uart_rx_scoreboard #(
        .MSG_LEN(MSG_LEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .expected(expected), .arm(arm),
        .stall(stall), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .overflow(overflow), .timeout(timeout), .mismatch_idx(mismatch_idx),
        .got_byte(got_byte), .rcv_count(rcv_count), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
    int         m_state = M_IDLE;
    logic [7:0] mq[$];
    int         m_rcv = 0, m_midx = 0, m_fec = 0, m_idle = 0;
    logic [7:0] m_got = 8'h00;
    bit         m_ovf = 0, m_to = 0;
    bit         m_decided;
    logic [7:0] m_b;

    function automatic logic [7:0] exp_byte(input int k);
        logic [8*MSG_LEN-1:0] t;
        t = expected >> (8 * k);
        return t[7:0];
    endfunction

    always @(posedge clk) begin
        if (rst || arm) begin
            mq.delete();
            m_rcv = 0; m_midx = 0; m_fec = 0; m_idle = 0;
            m_got = 8'h00; m_ovf = 0; m_to = 0;
            m_state = rst ? M_IDLE : M_RUN;
        end else if (m_state == M_RUN) begin
            m_decided = 0;
            if (rx_valid && rx_frame_err && m_fec < 255) m_fec++;
            if (mq.size() > 0 && !stall) begin
                m_b = mq.pop_front();
                if (m_b == exp_byte(m_rcv)) begin
                    m_rcv++;
                    if (m_rcv == MSG_LEN) begin m_state = M_PASS; m_decided = 1; end
                end else begin
                    m_midx = m_rcv; m_got = m_b; m_state = M_FAIL; m_decided = 1;
                end
            end
            if (rx_valid && !rx_frame_err) begin
                if (mq.size() < DEPTH) mq.push_back(rx_byte);
                else if (!m_decided) begin m_ovf = 1; m_state = M_FAIL; m_decided = 1; end
            end
`ifdef UART_RX_SCOREBOARD_TIMEOUT_EN
            if (rx_valid) m_idle = 0;
            else begin
                if (m_idle == TO - 1 && !m_decided) begin
                    m_to = 1; m_midx = m_rcv; m_state = M_FAIL;
                end
                m_idle++;
            end
`endif
        end
    end

    function automatic logic [31:0] dut_vec();
        return 32'({busy, done, pass, fail, overflow, timeout, mismatch_idx,
                    got_byte, rcv_count, frame_err_cnt});
    endfunction

    function automatic logic [31:0] model_vec();
        logic p, f;
        p = (m_state == M_PASS);
        f = (m_state == M_FAIL);
        return 32'({m_state == M_RUN, p | f, p, f, m_ovf, m_to, CW'(m_midx),
                    m_got, CW'(m_rcv), 8'(m_fec)});
    endfunction

    task automatic drive(input logic v, input logic fe, input logic [7:0] b, input bit flood);
        rx_valid = v; rx_frame_err = fe; rx_byte = b;
        stall = flood ? 1'b1 : ($urandom_range(0, 2) == 0);
        step();
        check("model", dut_vec(), model_vec());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       arm, valid, fe;
        logic [7:0] b;
        logic       busy, pass, fail;
        logic [2:0] rcv, midx;
        logic [7:0] got, fec;
    } vec_t;

    vec_t tbl[15];

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [23:0] exp_r;
        logic [7:0]  b;
        bit          flood;
        int          cnt;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h69, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 8'h00, 8'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h68, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 8'h00, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h00, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 8'h00, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h6A, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 8'h6A, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 8'h6A, 8'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 8'h6A, 8'd0};

        rst = 1'b1; rx_valid = 1'b0; rx_frame_err = 1'b0; arm = 1'b0; stall = 1'b0;
        rx_byte = 8'h00; expected = 24'h686921;
        repeat (3) step();
        check("reset_state", dut_vec(), 32'h0);
        rst = 1'b0;
        step();
        check("idle_after_reset", dut_vec(), 32'h0);

        // Table: row inputs applied for one cycle, outputs checked after the edge.
        for (int i = 0; i < 15; i++) begin
            arm = tbl[i].arm; rx_valid = tbl[i].valid; rx_frame_err = tbl[i].fe;
            rx_byte = tbl[i].b;
            step();
            check($sformatf("tbl[%0d]", i),
                  32'({busy, done, pass, fail, rcv_count, mismatch_idx, got_byte, frame_err_cnt}),
                  32'({tbl[i].busy, tbl[i].pass | tbl[i].fail, tbl[i].pass, tbl[i].fail,
                       tbl[i].rcv, tbl[i].midx, tbl[i].got, tbl[i].fec}));
        end
        arm = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0;

        // Overflow: stalled FIFO of 8 takes 8 bytes, the ninth overflows.
        arm = 1'b1; stall = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1; rx_byte = 8'h21; step();
        end
        check("ovf_before_9th", 32'({busy, overflow, fail}), 32'b100);
        step();
        rx_valid = 1'b0;
        check("ovf_after_9th", 32'({busy, overflow, fail, done}), 32'b0111);
        arm = 1'b1; step(); arm = 1'b0;
        check("rearm_clears", 32'({busy, overflow, fail, done, rcv_count}), 32'({4'b1000, 3'd0}));

        // Stall then release: bytes drain one per cycle.
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_byte = expected[8*i +: 8]; step();
        end
        rx_valid = 1'b0;
        step(); step();
        check("stall_holds", 32'({busy, rcv_count}), 32'({1'b1, 3'd0}));
        stall = 1'b0;
        step(); check("drain_1", 32'(rcv_count), 32'd1);
        step(); check("drain_2", 32'(rcv_count), 32'd2);
        step(); check("drain_3", 32'({pass, fail, rcv_count}), 32'({2'b10, 3'd3}));

        // rst in the middle of RUN.
        arm = 1'b1; step(); arm = 1'b0;
        rx_valid = 1'b1; rx_byte = 8'h21; step(); rx_valid = 1'b0;
        step();
        check("rst_pre_rcv", 32'(rcv_count), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_run", dut_vec(), 32'h0);
        rx_valid = 1'b1; rx_byte = 8'h69; step(); rx_byte = 8'h68; step(); rx_valid = 1'b0;
        step(); step();
        check("ignored_in_idle", dut_vec(), 32'h0);
        arm = 1'b1; step(); arm = 1'b0;
        check("arm_after_rst", 32'({busy, done}), 32'b10);

        // Frame-error counter saturates at 255 and never fails the check.
        rx_valid = 1'b1; rx_frame_err = 1'b1; rx_byte = 8'h55;
        repeat (260) step();
        rx_valid = 1'b0; rx_frame_err = 1'b0;
        check("fec_saturate", 32'({busy, fail, frame_err_cnt}), 32'({2'b10, 8'd255}));

        // Idle timeout.
        arm = 1'b1; step(); arm = 1'b0;
`ifdef UART_RX_SCOREBOARD_TIMEOUT_EN
        cnt = 0;
        while (!fail && cnt < 300) begin step(); cnt++; end
        check("timeout_latency", 32'(cnt), 32'(TO));
        check("timeout_flags", 32'({timeout, fail, mismatch_idx}), 32'({2'b11, 3'd0}));
`else
        cnt = 0;
        repeat (TO + 50) begin step(); cnt++; end
        check("no_timeout", 32'({busy, timeout, fail}), 32'b100);
`endif

        // Randomized messages against the reference model.
        for (int m = 0; m < 150; m++) begin
            exp_r = 24'($urandom);
            expected = exp_r;
            arm = 1'b1; drive(1'b0, 1'b0, 8'h00, 1'b0); arm = 1'b0;
            flood = ($urandom_range(0, 7) == 0);
            if (flood) begin
                repeat (10) drive(1'b1, 1'b0, 8'($urandom), 1'b1);
            end else begin
                for (int k = 0; k < MSG_LEN; k++) begin
                    repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 8'h00, 1'b0);
                    if ($urandom_range(0, 4) == 0) drive(1'b1, 1'b1, 8'($urandom), 1'b0);
                    b = exp_r[8*k +: 8];
                    if ($urandom_range(0, 7) == 0) b = b ^ (8'h01 << $urandom_range(0, 7));
                    drive(1'b1, 1'b0, b, 1'b0);
                end
            end
            repeat (12) drive(1'b0, 1'b0, 8'h00, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_scoreboard
`default_nettype wire

// File: doc/uart_rx_scoreboard.md
# uart_rx_scoreboard

Checker stage downstream of the bench-side UART receiver in the Caravel/Patmos DV environment. Accepts decoded bytes (byte + valid strobe + frame-error flag), buffers them in a small FIFO and compares them in order against an expected message. Reports pass/fail, mismatch position, frame-error count and an optional idle timeout. Gives the top-level bench a single `done`/`pass` pair to wait on.

## Interface
Parameters:
- `MSG_LEN`, 3, expected message length in bytes (≥1)
- `DEPTH`, 8, FIFO depth in bytes (power of two, ≥2)
- `TIMEOUT_CYCLES`, 150000, idle cycles in RUN before timeout (only with macro)

Ports:
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `rx_byte` in 8: received byte
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid
- `rx_frame_err` in 1: qualifies `rx_valid`; stop bit was missing
- `expected` in 8*MSG_LEN: byte k in bits [8k+7:8k]; byte 0 is first on the wire
- `arm` in 1: one-cycle pulse; start or restart a check
- `stall` in 1: inhibits compare/pop; exercises buffering
- `busy` out 1: state is RUN
- `done` out 1: pass | fail
- `pass` out 1: full message matched
- `fail` out 1: mismatch, overflow or timeout
- `overflow` out 1: sticky, byte dropped on full FIFO
- `timeout` out 1: sticky, idle timeout hit
- `mismatch_idx` out $clog2(MSG_LEN)+1: index of first mismatching byte
- `got_byte` out 8: byte received at `mismatch_idx`
- `rcv_count` out $clog2(MSG_LEN)+1: bytes matched so far
- `frame_err_cnt` out 8: saturating count of framed-bad bytes

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset → IDLE, all outputs 0, FIFO empty.
- `arm` in any state: flush FIFO, clear all flags and counters, go to RUN next cycle. Bytes strobed in the `arm` cycle are dropped.
- Push (RUN only): `rx_valid & ~rx_frame_err`. Push is accepted if FIFO not full, or if a pop happens in the same cycle. Otherwise set `overflow` and go to FAIL. The byte is lost.
- `rx_valid & rx_frame_err` in RUN: no push; `frame_err_cnt` increments, saturating at 255. This is not a failure.
- Pop/compare (RUN): FIFO non-empty and `~stall` → pop one byte and compare with `expected` byte `rcv_count`.
  - Match: `rcv_count`+1. If `rcv_count` was MSG_LEN-1, go to PASS.
  - Mismatch: latch `mismatch_idx`=`rcv_count` and `got_byte`; go to FAIL.
- In IDLE/PASS/FAIL, `rx_valid` is ignored and no counters change. Leftover FIFO contents are not examined.
- `expected` is sampled at each compare and must be held stable while in RUN.

## Timing
- `rx_valid` at cycle N with empty FIFO and `stall`=0 → byte popped at edge N+1. Verdict outputs (`pass`/`fail`/`rcv_count`) are registered and change at N+2.
- Throughput: one push and one pop per cycle.
- Overflow `fail` is asserted the cycle after the offending strobe.
- `stall` held high: compares stop and the FIFO fills. Releasing `stall` drains one byte per cycle.
- `rst` mid-RUN: returns to IDLE next edge; all outputs and the FIFO are cleared.
- `done`, `pass` and `fail` stay asserted until `arm` or `rst`.

## Configuration
- `UART_RX_SCOREBOARD_TIMEOUT_EN` defined:
  - An idle counter runs in RUN and clears on any `rx_valid`.
  - When it reaches TIMEOUT_CYCLES-1, set `timeout` and go to FAIL next edge.
  - `mismatch_idx` then equals `rcv_count`.
- Not defined: no counter is built, `timeout` is tied 0, and RUN waits indefinitely.

## Structure
- Package `uart_rx_scoreboard_pkg` holds:
  - state enum `sb_state_t` (IDLE, RUN, PASS, FAIL)
  - `FRAME_ERR_MAX` = 255
  - the byte-width localparam
- Sub-module `uart_sb_fifo`: synchronous FIFO with `flush`, `push`, `pop`, `full`, `empty` and same-cycle push/pop when full. Read data is first-word-fall-through.

## Test plan
- Arm; strobe 0x21, 0x69, 0x68, 20 cycles apart, with `expected`=24'h686921 → `pass`=1 two cycles after the last strobe, `rcv_count`=3, `fail`=0.
- Same, but the second byte is 0x6A → `fail`=1, `mismatch_idx`=1, `got_byte`=0x6A, `rcv_count`=1.
- Strobe a 0x55 with `rx_frame_err`=1 between good bytes → `frame_err_cnt`=1, still `pass`.
- DEPTH=8, `stall`=1, MSG_LEN=16, nine back-to-back good strobes → `overflow`=1 and `fail`=1 after the ninth. Then re-arm → flags cleared, `busy`=1.
- Macro on, TIMEOUT_CYCLES=100: arm, send nothing → `timeout`=`fail`=1 exactly 100 cycles after entering RUN.
- Assert `rst` after the first matched byte → next cycle all outputs 0, `busy`=0; later strobes are ignored until `arm`.
